// File: rtl/data_memory.sv
// Byte-addressed, word-organised data memory with sub-word loads/stores,
// sign/zero extension, alignment checking and a sticky first-fault latch.
module data_memory #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        ErrFlag,
  output logic [31:0] ErrAddr
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] r_mem [DEPTH];
  logic        r_err_flag;
  logic [31:0] r_err_addr;

  logic [ADDR_WIDTH-3:0] w_index;
  logic [1:0]            w_offset;
  logic                  w_access;
  logic                  w_illegal;
  logic                  w_fault;
  logic [31:0]           w_word;
  logic [31:0]           w_load;
  logic [31:0]           w_store_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr_hi;

  assign w_index  = Address[ADDR_WIDTH-1:2];
  assign w_offset = Address[1:0];
  assign w_access = MemRead | MemWrite;
  assign w_word   = r_mem[w_index];
  // High address bits wrap silently; they never contribute to a fault.
  assign w_unused_addr_hi = ^Address[31:ADDR_WIDTH];

  always_comb begin
    w_illegal = 1'b0;
    case (MemSize)
      SZ_BYTE: w_illegal = 1'b0;
      SZ_HALF: w_illegal = w_offset[0];
      SZ_WORD: w_illegal = (w_offset != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_fault = w_access & w_illegal;

  always_comb begin
    w_byte = w_word[{w_offset, 3'b000} +: 8];
    w_half = w_word[{w_offset[1], 4'b0000} +: 16];
    w_load = 32'd0;
    if (MemRead && !w_fault) begin
      case (MemSize)
        SZ_BYTE: w_load = {{24{MemSigned & w_byte[7]}}, w_byte};
        SZ_HALF: w_load = {{16{MemSigned & w_half[15]}}, w_half};
        default: w_load = w_word;
      endcase
    end
  end

  // Merge the store lanes into the current word; untouched lanes keep old data.
  always_comb begin
    w_store_word = w_word;
    case (MemSize)
      SZ_BYTE: w_store_word[{w_offset, 3'b000} +: 8]     = WriteData[7:0];
      SZ_HALF: w_store_word[{w_offset[1], 4'b0000} +: 16] = WriteData[15:0];
      default: w_store_word = WriteData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
      r_err_flag <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      if (MemWrite && !w_fault) begin
        r_mem[w_index] <= w_store_word;
      end
      if (w_fault && !r_err_flag) begin
        r_err_flag <= 1'b1;
        r_err_addr <= Address;
      end
    end
  end

  assign ReadData = w_load;
  assign Fault    = w_fault;
  assign ErrFlag  = r_err_flag;
  assign ErrAddr  = r_err_addr;

endmodule

// File: tb/tb_data_memory.sv
// Directed scoreboard bench for data_memory: expectations are queued as each
// cycle is driven and drained against the DUT at the following falling edge.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] ReadData;
  logic        Fault;
  logic        ErrFlag;
  logic [31:0] ErrAddr;

  data_memory #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .MemSize   (MemSize),
    .MemSigned (MemSigned),
    .ReadData  (ReadData),
    .Fault     (Fault),
    .ErrFlag   (ErrFlag),
    .ErrAddr   (ErrAddr)
  );

  localparam int SEL_RD  = 0;
  localparam int SEL_FLT = 1;
  localparam int SEL_EF  = 2;
  localparam int SEL_EA  = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic re, input logic [1:0] sz,
                       input logic sg);
    rst       = r;
    Address   = a;
    WriteData = wd;
    MemWrite  = we;
    MemRead   = re;
    MemSize   = sz;
    MemSigned = sg;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Compare every queued expectation at the falling edge, then advance a cycle.
  task automatic settle();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RD:  obs = ReadData;
        SEL_FLT: obs = {31'd0, Fault};
        SEL_EF:  obs = {31'd0, ErrFlag};
        default: obs = ErrAddr;
      endcase
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_val("reset_rd", SEL_RD, 32'h0);
    expect_val("reset_fault", SEL_FLT, 32'h0);
    expect_val("reset_errflag", SEL_EF, 32'h0);
    expect_val("reset_erraddr", SEL_EA, 32'h0);
    settle();

    drive(1'b0, 32'h010, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0);
    expect_val("st_word_fault", SEL_FLT, 32'h0);
    expect_val("st_word_rd_idle", SEL_RD, 32'h0);
    settle();

    drive(1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("ld_word", SEL_RD, 32'hDEADBEEF);
    expect_val("ld_word_fault", SEL_FLT, 32'h0);
    expect_val("ld_word_errflag", SEL_EF, 32'h0);
    settle();

    drive(1'b0, 32'h013, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    expect_val("ld_byte3_s", SEL_RD, 32'hFFFFFFDE);
    settle();
    drive(1'b0, 32'h013, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    expect_val("ld_byte3_u", SEL_RD, 32'h000000DE);
    settle();

    drive(1'b0, 32'h011, 32'hFFFFFF5A, 1'b1, 1'b0, 2'b00, 1'b0);
    expect_val("st_byte_fault", SEL_FLT, 32'h0);
    settle();
    drive(1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("ld_after_byte_st", SEL_RD, 32'hDEAD5AEF);
    settle();
    drive(1'b0, 32'h012, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    expect_val("ld_byte2_s", SEL_RD, 32'hFFFFFFAD);
    settle();
    drive(1'b0, 32'h011, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    expect_val("ld_byte1_u", SEL_RD, 32'h0000005A);
    settle();
    drive(1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    expect_val("ld_half0_s_pos", SEL_RD, 32'h00005AEF);
    settle();
    drive(1'b0, 32'h012, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    expect_val("ld_half1_s_neg", SEL_RD, 32'hFFFFDEAD);
    settle();

    drive(1'b0, 32'h022, 32'hABCD8001, 1'b1, 1'b0, 2'b01, 1'b0);
    expect_val("st_half_fault", SEL_FLT, 32'h0);
    settle();
    drive(1'b0, 32'h022, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    expect_val("ld_half_s", SEL_RD, 32'hFFFF8001);
    settle();
    drive(1'b0, 32'h022, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
    expect_val("ld_half_u", SEL_RD, 32'h00008001);
    settle();
    drive(1'b0, 32'h020, 32'h0, 1'b0, 1'b1, 2'b10, 1'b1);
    expect_val("ld_word_after_half", SEL_RD, 32'h80010000);
    settle();

    drive(1'b0, 32'h033, 32'hFFFFFFFF, 1'b0, 1'b0, 2'b11, 1'b0);
    expect_val("idle_illegal_fault", SEL_FLT, 32'h0);
    expect_val("idle_illegal_rd", SEL_RD, 32'h0);
    settle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    expect_val("idle_no_latch", SEL_EF, 32'h0);
    settle();

    drive(1'b0, 32'h032, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 1'b0);
    expect_val("misalign_st_fault", SEL_FLT, 32'h1);
    expect_val("misalign_st_ef_same", SEL_EF, 32'h0);
    settle();
    drive(1'b0, 32'h030, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("misalign_no_write", SEL_RD, 32'h0);
    expect_val("misalign_errflag", SEL_EF, 32'h1);
    expect_val("misalign_erraddr", SEL_EA, 32'h032);
    settle();

    drive(1'b0, 32'h041, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    expect_val("second_fault", SEL_FLT, 32'h1);
    expect_val("second_fault_rd", SEL_RD, 32'h0);
    settle();
    drive(1'b0, 32'h040, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0);
    expect_val("reserved_rd", SEL_RD, 32'h0);
    expect_val("reserved_fault", SEL_FLT, 32'h1);
    expect_val("erraddr_sticky", SEL_EA, 32'h032);
    expect_val("errflag_sticky", SEL_EF, 32'h1);
    settle();

    drive(1'b0, 32'h050, 32'h11111111, 1'b1, 1'b0, 2'b10, 1'b0);
    settle();
    drive(1'b0, 32'h050, 32'h22222222, 1'b1, 1'b1, 2'b10, 1'b0);
    expect_val("rw_same_cycle_old", SEL_RD, 32'h11111111);
    expect_val("rw_same_cycle_fault", SEL_FLT, 32'h0);
    settle();
    drive(1'b0, 32'h050, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("rw_next_cycle_new", SEL_RD, 32'h22222222);
    settle();
    drive(1'b0, 32'h450, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("wrap_load", SEL_RD, 32'h22222222);
    expect_val("wrap_load_fault", SEL_FLT, 32'h0);
    settle();
    drive(1'b0, 32'h854, 32'h33333333, 1'b1, 1'b0, 2'b10, 1'b0);
    settle();
    drive(1'b0, 32'h054, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("wrap_store", SEL_RD, 32'h33333333);
    settle();

    drive(1'b1, 32'h060, 32'h12345678, 1'b1, 1'b0, 2'b10, 1'b0);
    expect_val("pre_rst_errflag", SEL_EF, 32'h1);
    settle();
    drive(1'b0, 32'h060, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("rst_discards_store", SEL_RD, 32'h0);
    expect_val("rst_clears_errflag", SEL_EF, 32'h0);
    expect_val("rst_clears_erraddr", SEL_EA, 32'h0);
    settle();
    drive(1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_val("rst_clears_mem", SEL_RD, 32'h0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
